// File: rtl/mac_pkg.sv
// Shared widths and beat types for the MAC normalization stage.
// Gradual-underflow support is selected by the MAC_NORM_DENORM_EN macro.
package mac_pkg;

    localparam int MAC_EXP_W  = 8;
    localparam int MAC_MANT_W = 32;
    localparam int MAC_LZ_W   = 5;

    // Captured input beat held in the first pipeline stage
    typedef struct packed {
        logic                  sign;
        logic [MAC_EXP_W-1:0]  exp;
        logic [MAC_MANT_W-1:0] mant;
        logic [MAC_LZ_W-1:0]   lz;
        logic                  zero;
    } raw_beat_t;

    // Normalized result beat presented on the output
    typedef struct packed {
        logic                  sign;
        logic [MAC_EXP_W-1:0]  exp;
        logic [MAC_MANT_W-1:0] mant;
        logic                  zero;
        logic                  uflow;
    } norm_beat_t;

endpackage

// File: rtl/mac_norm_shift.sv
// Combinational normalize/adjust of one captured beat.
// MAC_NORM_DENORM_EN selects gradual underflow; otherwise underflow flushes to zero.
module mac_norm_shift
    import mac_pkg::*;
(
    input  logic                  sign,
    input  logic [MAC_EXP_W-1:0]  exp,
    input  logic [MAC_MANT_W-1:0] mant,
    input  logic [MAC_LZ_W-1:0]   lz,
    input  logic                  zero,
    output norm_beat_t            beat
);

    localparam logic [MAC_EXP_W-1:0] EXP_ONE = {{(MAC_EXP_W-1){1'b0}}, 1'b1};

    logic [MAC_EXP_W:0]   diff_s;
    logic                 uflow_s;
    logic [MAC_LZ_W-1:0]  dn_shift_s;

    // Exponent adjust, underflow detection and mantissa shift
    always_comb begin
        diff_s     = {1'b0, exp} - {{(MAC_EXP_W+1-MAC_LZ_W){1'b0}}, lz};
        // A borrow or a zero result both land on the reserved exponent 0.
        uflow_s    = diff_s[MAC_EXP_W] | (diff_s[MAC_EXP_W-1:0] == {MAC_EXP_W{1'b0}});
        // Only reached when exp <= lz, so exp-1 always fits the shift width.
        dn_shift_s = (exp == {MAC_EXP_W{1'b0}}) ? {MAC_LZ_W{1'b0}}
                                                : MAC_LZ_W'(exp - EXP_ONE);

        beat       = '0;
        beat.sign  = sign;
        if (zero) begin
            beat.zero = 1'b1;
        end else if (uflow_s) begin
            beat.uflow = 1'b1;
`ifdef MAC_NORM_DENORM_EN
            beat.mant  = mant << dn_shift_s;
`else
            beat.zero  = 1'b1;
`endif
        end else begin
            beat.mant = mant << lz;
            beat.exp  = diff_s[MAC_EXP_W-1:0];
        end
    end

endmodule

// File: rtl/mac_normalizer.sv
// Two-stage valid/ready normalization pipeline following the leading-zero detector.
// Build option MAC_NORM_DENORM_EN enables gradual underflow instead of flush-to-zero.
module mac_normalizer
    import mac_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [4:0]        in_lz,
    input  logic              in_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_zero,
    output logic              out_uflow
);

    logic       s1_valid_q, s1_valid_d;
    raw_beat_t  s1_q, s1_d;
    logic       out_valid_q, out_valid_d;
    norm_beat_t out_q, out_d;

    logic       s2_adv_s;
    logic       in_fire_s;
    norm_beat_t shift_beat_s;

    mac_norm_shift u_shift (
        .sign (s1_q.sign),
        .exp  (s1_q.exp),
        .mant (s1_q.mant),
        .lz   (s1_q.lz),
        .zero (s1_q.zero),
        .beat (shift_beat_s)
    );

    // Handshake: in_ready depends on out_ready and state only, never on in_valid
    always_comb begin
        s2_adv_s  = s1_valid_q && (!out_valid_q || out_ready);
        in_ready  = !s1_valid_q || s2_adv_s;
        in_fire_s = in_valid && in_ready;
    end

    // Next-state for both stages
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_d        = s1_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;

        if (in_fire_s) begin
            s1_valid_d = 1'b1;
            s1_d.sign  = in_sign;
            s1_d.exp   = in_exp;
            s1_d.mant  = in_mant;
            s1_d.lz    = in_lz;
            s1_d.zero  = in_zero;
        end else if (s2_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (s2_adv_s) begin
            out_valid_d = 1'b1;
            out_d       = shift_beat_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sign  = out_q.sign;
    assign out_exp   = out_q.exp;
    assign out_mant  = out_q.mant;
    assign out_zero  = out_q.zero;
    assign out_uflow = out_q.uflow;

endmodule

// File: tb/tb_mac_normalizer.sv
// Directed self-checking bench for mac_normalizer (honours MAC_NORM_DENORM_EN).
module tb_mac_normalizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_sign, in_zero;
    logic [7:0]  in_exp;
    logic [31:0] in_mant;
    logic [4:0]  in_lz;
    logic        out_valid, out_ready, out_sign, out_zero, out_uflow;
    logic [7:0]  out_exp;
    logic [31:0] out_mant;

    int n_tests = 0;
    int n_fail  = 0;
    int accepted;

    logic [31:0] st_mant [16];
    logic [7:0]  st_exp  [16];
    logic [4:0]  st_lz   [16];
    logic        st_sign [16];
    logic [31:0] ex_mant [16];
    logic [7:0]  ex_exp  [16];

    always #5 clk = ~clk;

    mac_normalizer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
        .in_exp(in_exp), .in_mant(in_mant), .in_lz(in_lz), .in_zero(in_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
        .out_exp(out_exp), .out_mant(out_mant), .out_zero(out_zero),
        .out_uflow(out_uflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Beat i: lz=i, a leading one at bit 31-i plus bit 0, so the result is 0x8000_0000 | (1<<i)
    task automatic fill_stream(input int n);
        for (int i = 0; i < n; i++) begin
            st_lz[i]   = 5'(i);
            st_mant[i] = (32'h8000_0000 >> i) | 32'h0000_0001;
            st_exp[i]  = 8'h20 + 8'(2 * i);
            st_sign[i] = 1'(i);
            ex_mant[i] = 32'h8000_0000 | (32'h0000_0001 << i);
            ex_exp[i]  = 8'h20 + 8'(i);
        end
    endtask

    task automatic drive_stream(input int n, input bit chk_ready);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int guard;
            in_valid = 1'b1; in_sign = st_sign[i]; in_exp = st_exp[i];
            in_mant  = st_mant[i]; in_lz = st_lz[i]; in_zero = 1'b0;
            acc = 1'b0; guard = 0;
            while (!acc && guard < 100) begin
                @(negedge clk);
                acc = in_ready;
                if (chk_ready) check("b2b_in_ready", 64'(in_ready), 64'd1);
                @(posedge clk); #1;
                guard++;
            end
            if (!acc) check("drive_timeout", 64'd0, 64'd1);
            else accepted++;
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input int n, input bit chk_consec);
        int idx = 0, cyc = 0, first = -1, last = 0;
        while (idx < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (out_valid && out_ready) begin
                if (first < 0) first = cyc;
                last = cyc;
                check($sformatf("stream_mant[%0d]", idx), 64'(out_mant), 64'(ex_mant[idx]));
                check($sformatf("stream_exp[%0d]", idx), 64'(out_exp), 64'(ex_exp[idx]));
                check($sformatf("stream_sign[%0d]", idx), 64'(out_sign), 64'(st_sign[idx]));
                idx++;
            end
        end
        if (idx < n) check("collect_timeout", 64'(idx), 64'(n));
        if (chk_consec) check("consecutive", 64'(last - first), 64'(n - 1));
    endtask

    task automatic single(input string tag, input logic sg, input logic [7:0] ex,
                          input logic [31:0] mt, input logic [4:0] lz, input logic zr,
                          input logic [31:0] e_mant, input logic [7:0] e_exp,
                          input logic e_zero, input logic e_uflow);
        @(posedge clk); #1;
        in_valid = 1'b1; in_sign = sg; in_exp = ex; in_mant = mt; in_lz = lz; in_zero = zr;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat1"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_mant"},  64'(out_mant),  64'(e_mant));
        check({tag, "_exp"},   64'(out_exp),   64'(e_exp));
        check({tag, "_zero"},  64'(out_zero),  64'(e_zero));
        check({tag, "_uflow"}, 64'(out_uflow), 64'(e_uflow));
        check({tag, "_sign"},  64'(out_sign),  64'(sg));
    endtask

    initial begin
        logic [31:0] held;
        rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'h00;
        in_mant = 32'h0; in_lz = 5'd0; in_zero = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outs", 64'({out_sign, out_exp, out_mant, out_zero, out_uflow}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        single("norm",  1'b0, 8'h40, 32'h0000_1234, 5'd19, 1'b0, 32'h91A0_0000, 8'h2D, 1'b0, 1'b0);
        single("zero",  1'b1, 8'h55, 32'h0000_0000, 5'd7,  1'b1, 32'h0000_0000, 8'h00, 1'b1, 1'b0);
        single("lz0",   1'b1, 8'h80, 32'h8000_0001, 5'd0,  1'b0, 32'h8000_0001, 8'h80, 1'b0, 1'b0);
        single("edge1", 1'b0, 8'd24, 32'h0000_0100, 5'd23, 1'b0, 32'h8000_0000, 8'h01, 1'b0, 1'b0);
`ifdef MAC_NORM_DENORM_EN
        single("uf",    1'b0, 8'h05, 32'h0000_0100, 5'd23, 1'b0, 32'h0000_1000, 8'h00, 1'b0, 1'b1);
        single("uf_eq", 1'b1, 8'd23, 32'h0000_0100, 5'd23, 1'b0, 32'h4000_0000, 8'h00, 1'b0, 1'b1);
        single("uf_e0", 1'b0, 8'h00, 32'h0000_0100, 5'd23, 1'b0, 32'h0000_0100, 8'h00, 1'b0, 1'b1);
`else
        single("uf",    1'b0, 8'h05, 32'h0000_0100, 5'd23, 1'b0, 32'h0000_0000, 8'h00, 1'b1, 1'b1);
        single("uf_eq", 1'b1, 8'd23, 32'h0000_0100, 5'd23, 1'b0, 32'h0000_0000, 8'h00, 1'b1, 1'b1);
        single("uf_e0", 1'b0, 8'h00, 32'h0000_0100, 5'd23, 1'b0, 32'h0000_0000, 8'h00, 1'b1, 1'b1);
`endif

        // Back-to-back stream at full throughput
        @(posedge clk); #1;
        fill_stream(8);
        accepted = 0;
        fork
            drive_stream(8, 1'b1);
            collect(8, 1'b1);
        join
        check("b2b_accepted", 64'(accepted), 64'd8);

        // Backpressure: consumer stalls for 5 cycles under a continuous stream
        @(posedge clk); #1;
        out_ready = 1'b0;
        fill_stream(6);
        accepted = 0;
        fork
            drive_stream(6, 1'b0);
            begin
                repeat (3) @(negedge clk);
                held = out_mant;
                check("bp_valid", 64'(out_valid), 64'd1);
                check("bp_first", 64'(held), 64'(ex_mant[0]));
                repeat (3) @(negedge clk);
                check("bp_accepted", 64'(accepted), 64'd2);
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_hold", 64'(out_mant), 64'(held));
                @(posedge clk); #1;
                out_ready = 1'b1;
                collect(6, 1'b0);
            end
        join
        check("bp_total", 64'(accepted), 64'd6);

        // Reset with both stages full
        @(posedge clk); #1;
        out_ready = 1'b0;
        fill_stream(2);
        accepted = 0;
        drive_stream(2, 1'b0);
        @(negedge clk);
        check("full_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_outs", 64'({out_sign, out_exp, out_mant, out_zero, out_uflow}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        single("recover", 1'b0, 8'h40, 32'h0000_1234, 5'd19, 1'b0, 32'h91A0_0000, 8'h2D, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
